// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat channel shared by both sides of the packet FIFO.
// Signals: tvalid, tready, tdata[DATA_W], tlast; master drives all but tready.
interface axis_pkt_fifo_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXIS packet FIFO: first-word fall-through, tlast-aware packet counting.
// Ports: aclk, aresetn (async low), s_axis (slave), m_axis (master),
//   fill_count / pkt_count (AW+1 bits each).
// Macro AXIS_PKT_FIFO_SAF_EN enables store-and-forward with overlong bypass.
module axis_pkt_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axis_pkt_fifo_if.slave          s_axis,
  axis_pkt_fifo_if.master         m_axis,
  output logic [AW:0]             fill_count,
  output logic [AW:0]             pkt_count
);

  localparam logic [AW:0] ONE = 1;

  logic [DATA_W:0] mem_q [DEPTH];

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [AW:0] fill_q, fill_d;
  logic [AW:0] pkt_q, pkt_d;
  logic        open_q;

  logic        empty, full;
  logic        push, pop;
  logic        pkt_in, pkt_out;
  logic [DATA_W:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign head = mem_q[rd_q[AW-1:0]];

  // open_q keeps tready low while in reset and for the release edge.
  assign s_axis.tready = open_q & ~full;
  assign m_axis.tdata  = head[DATA_W-1:0];
  assign m_axis.tlast  = head[DATA_W];

`ifdef AXIS_PKT_FIFO_SAF_EN
  logic bypass_q, bypass_d;

  // Bypass lets a packet longer than the FIFO stream through.
  assign m_axis.tvalid = ~empty & ((pkt_q != '0) | bypass_q);

  always_comb begin
    bypass_d = bypass_q;
    if (pkt_out)
      bypass_d = 1'b0;
    else if (full && pkt_q == '0)
      bypass_d = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) bypass_q <= 1'b0;
    else          bypass_q <= bypass_d;
  end
`else
  assign m_axis.tvalid = ~empty;
`endif

  assign push    = s_axis.tvalid & s_axis.tready;
  assign pop     = m_axis.tvalid & m_axis.tready;
  assign pkt_in  = push & s_axis.tlast;
  assign pkt_out = pop & head[DATA_W];

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    pkt_d  = pkt_q;
    if (push) wr_d = wr_q + ONE;
    if (pop)  rd_d = rd_q + ONE;
    case ({push, pop})
      2'b10:   fill_d = fill_q + ONE;
      2'b01:   fill_d = fill_q - ONE;
      default: fill_d = fill_q;
    endcase
    case ({pkt_in, pkt_out})
      2'b10:   pkt_d = pkt_q + ONE;
      2'b01:   pkt_d = pkt_q - ONE;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      pkt_q  <= '0;
      open_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      pkt_q  <= pkt_d;
      open_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
  end

  assign fill_count = fill_q;
  assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo (DATA_W=8, DEPTH=16).
// Store-and-forward steps run when AXIS_PKT_FIFO_SAF_EN is defined.
module tb_axis_pkt_fifo;
  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [4:0] fill_count;
  logic [4:0] pkt_count;

  int total = 0;
  int bad   = 0;

  axis_pkt_fifo_if #(.DATA_W(8)) s_if ();
  axis_pkt_fifo_if #(.DATA_W(8)) m_if ();

  axis_pkt_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .fill_count (fill_count),
    .pkt_count  (pkt_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic l);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tlast  = l;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    m_if.tready = 1'b0;
    #2;
    chk("rst_s_tready", 32'(s_if.tready), 0);
    chk("rst_m_tvalid", 32'(m_if.tvalid), 0);
    chk("rst_fill", 32'(fill_count), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    #21 aresetn = 1'b1;
    step();
    chk("rel_s_tready", 32'(s_if.tready), 1);

`ifndef AXIS_PKT_FIFO_SAF_EN
    // 1: cut-through
    m_if.tready = 1'b1;
    drive(1'b1, 8'h11, 1'b0);
    step();
    chk("ct_v0", 32'(m_if.tvalid), 1);
    chk("ct_d0", 32'(m_if.tdata), 32'h11);
    chk("ct_l0", 32'(m_if.tlast), 0);
    drive(1'b1, 8'h22, 1'b0);
    step();
    chk("ct_d1", 32'(m_if.tdata), 32'h22);
    chk("ct_l1", 32'(m_if.tlast), 0);
    drive(1'b1, 8'h33, 1'b1);
    step();
    chk("ct_d2", 32'(m_if.tdata), 32'h33);
    chk("ct_l2", 32'(m_if.tlast), 1);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk("ct_v_end", 32'(m_if.tvalid), 0);
    chk("ct_fill_end", 32'(fill_count), 0);
    chk("ct_pkt_end", 32'(pkt_count), 0);

    // 2: fill to DEPTH, held beat, single pop
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h40 + i), i == 15);
      step();
    end
    chk("full_s_tready", 32'(s_if.tready), 0);
    chk("full_fill", 32'(fill_count), 16);
    chk("full_pkt", 32'(pkt_count), 1);
    drive(1'b1, 8'h50, 1'b1);
    step();
    chk("held_fill", 32'(fill_count), 16);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    chk("pop1_fill", 32'(fill_count), 15);
    chk("pop1_s_tready", 32'(s_if.tready), 1);
    chk("pop1_head", 32'(m_if.tdata), 32'h41);
    step();
    chk("held_push_fill", 32'(fill_count), 16);
    drive(1'b0, 8'h00, 1'b0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_v", 32'(m_if.tvalid), 1);
      chk("drain_d", 32'(m_if.tdata), (i < 15) ? 32'h41 + i : 32'h50);
      step();
    end
    chk("drain_fill", 32'(fill_count), 0);
    chk("drain_pkt", 32'(pkt_count), 0);

    // 3: simultaneous push/pop at fill 5
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0);
      step();
    end
    chk("sim_fill5", 32'(fill_count), 5);
    m_if.tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h65 + i), 1'b0);
      chk("sim_d", 32'(m_if.tdata), 32'h60 + i);
      step();
      chk("sim_fill", 32'(fill_count), 5);
    end
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("sim_tail", 32'(m_if.tdata), 32'h6A + i);
      step();
    end
    chk("sim_empty", 32'(fill_count), 0);

    // 4: packet count
    m_if.tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h70 + i), (i == 3) || (i == 5));
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("pk_pkt2", 32'(pkt_count), 2);
    chk("pk_fill6", 32'(fill_count), 6);
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    m_if.tready = 1'b0;
    chk("pk_pkt1", 32'(pkt_count), 1);
    chk("pk_fill2", 32'(fill_count), 2);
    chk("pk_head", 32'(m_if.tdata), 32'h74);
    m_if.tready = 1'b1;
    step();
    step();
    chk("pk_pkt0", 32'(pkt_count), 0);
    chk("pk_fill0", 32'(fill_count), 0);

    // 5: async reset mid-packet
    m_if.tready = 1'b0;
    drive(1'b1, 8'hA0, 1'b0);
    step();
    drive(1'b1, 8'hA1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("mr_fill2", 32'(fill_count), 2);
    #2 aresetn = 1'b0;
    #1;
    chk("mr_m_tvalid", 32'(m_if.tvalid), 0);
    chk("mr_fill", 32'(fill_count), 0);
    chk("mr_pkt", 32'(pkt_count), 0);
    chk("mr_s_tready", 32'(s_if.tready), 0);
    step();
    #3 aresetn = 1'b1;
    step();
    chk("mr_rel_ready", 32'(s_if.tready), 1);
    m_if.tready = 1'b1;
    drive(1'b1, 8'hB0, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("mr_v", 32'(m_if.tvalid), 1);
    chk("mr_d", 32'(m_if.tdata), 32'hB0);
    chk("mr_l", 32'(m_if.tlast), 1);
    step();
    chk("mr_end_fill", 32'(fill_count), 0);
`else
    // 6: store-and-forward
    begin
      int rx, tx;
      logic p, q;
      m_if.tready = 1'b1;
      drive(1'b1, 8'h01, 1'b0);
      step();
      chk("saf_v_a", 32'(m_if.tvalid), 0);
      drive(1'b1, 8'h02, 1'b0);
      step();
      chk("saf_v_b", 32'(m_if.tvalid), 0);
      drive(1'b1, 8'h03, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("saf_v_c", 32'(m_if.tvalid), 1);
      for (int i = 0; i < 3; i++) begin
        chk("saf_d", 32'(m_if.tdata), 32'h01 + i);
        step();
      end
      chk("saf_empty", 32'(fill_count), 0);
      m_if.tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, 8'(8'h80 + i), 1'b0);
        step();
      end
      chk("saf_full_fill", 32'(fill_count), 16);
      chk("saf_full_v", 32'(m_if.tvalid), 0);
      drive(1'b1, 8'h90, 1'b0);
      step();
      chk("saf_byp_v", 32'(m_if.tvalid), 1);
      chk("saf_byp_d", 32'(m_if.tdata), 32'h80);
      m_if.tready = 1'b1;
      rx = 0;
      tx = 16;
      for (int c = 0; c < 60 && rx < 20; c++) begin
        drive(tx < 20, 8'(8'h80 + tx), tx == 19);
        p = s_if.tvalid && s_if.tready;
        q = m_if.tvalid;
        if (q) begin
          chk("saf_long_d", 32'(m_if.tdata), 32'h80 + rx);
          chk("saf_long_l", 32'(m_if.tlast), 32'(rx == 19));
        end
        step();
        if (p) tx++;
        if (q) rx++;
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("saf_long_count", 32'(rx), 20);
      chk("saf_long_fill", 32'(fill_count), 0);
      chk("saf_long_v", 32'(m_if.tvalid), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
